// File: rtl/pcfx_bk_pkg.sv
// Shared types for the backup-RAM SD sequencer.
// Operation, FSM state and sector geometry.
package pcfx_bk_pkg;

    typedef enum logic [1:0] {
        NONE,
        LOAD,
        SAVE
    } bk_op_t;

    typedef enum logic [2:0] {
        ACKLOW,
        IDLE,
        REQ,
        XFER,
        NEXT
    } bk_state_t;

    localparam int SECTOR_WORDS = 256;
    localparam int SECTOR_SHIFT = 9;

    // Byte size to sector count, clamped to the array capacity.
    function automatic logic [31:0] size_to_nsec(
        input logic [63:0] size,
        input logic [31:0] cap
    );
        logic [31:0] n;
        n = size[SECTOR_SHIFT+31:SECTOR_SHIFT];
        return (n > cap) ? cap : n;
    endfunction

endpackage

// File: rtl/bk_vd_state.sv
// Per-virtual-disk mount information and pending load/save bits.
// One instance per backup-RAM image.
module bk_vd_state
    import pcfx_bk_pkg::*;
#(
    parameter int MAX_SEC = 64,
    parameter int SEC_AW  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              mount,
    input  logic              img_readonly,
    input  logic [63:0]       img_size,
    input  logic              load_req,
    input  logic              save_req,
    input  logic              take_load,
    input  logic              take_save,
    output logic              mounted,
    output logic [SEC_AW:0]   nsec,
    output logic              pend_load,
    output logic              pend_save
);

    logic [31:0] new_nsec;
    logic        new_mounted;
    logic        ro;

    assign new_nsec    = size_to_nsec(img_size, 32'(MAX_SEC));
    assign new_mounted = (img_size != '0) && (new_nsec != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mounted   <= 1'b0;
            ro        <= 1'b0;
            nsec      <= '0;
            pend_load <= 1'b0;
            pend_save <= 1'b0;
        end else begin
            if (take_load) pend_load <= 1'b0;
            if (take_save) pend_save <= 1'b0;
            // A mount re-arms the auto-load and drops any stale save.
            if (mount) begin
                mounted   <= new_mounted;
                ro        <= img_readonly;
                nsec      <= new_nsec[SEC_AW:0];
                pend_load <= new_mounted;
                pend_save <= 1'b0;
            end else if (load_req && mounted) begin
                pend_load <= 1'b1;
                pend_save <= 1'b0;
            end else if (save_req && mounted && !ro) begin
                pend_save <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/bkram_sd_ctrl.sv
// Backup-RAM sector sequencer between hps_io SD channel and the RAM arrays.
// Handles auto-load on mount plus OSD load/save, VD0 before VD1.
module bkram_sd_ctrl
    import pcfx_bk_pkg::*;
#(
    parameter int INT_SECTORS = 64,
    parameter int BMP_SECTORS = 256,
    parameter int SEC_AW      = 8
) (
    input  logic        clk_sys,
    input  logic        reset_n,
    input  logic [1:0]  img_mounted,
    input  logic        img_readonly,
    input  logic [63:0] img_size,
    input  logic        bk_load,
    input  logic        bk_save,
    output logic        bk_ena,
    output logic        bk_busy,
    output logic [31:0] sd_lba,
    output logic [1:0]  sd_rd,
    output logic [1:0]  sd_wr,
    input  logic [1:0]  sd_ack,
    input  logic [7:0]  sd_buff_addr,
    input  logic [15:0] sd_buff_dout,
    output logic [15:0] sd_buff_din,
    input  logic        sd_buff_wr,
    output logic        mem_sel,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    output logic        mem_we,
    input  logic [15:0] mem_rdata
);

    logic            load_q, save_q;
    logic            load_edge, save_edge;
    logic [1:0]      mounted, pend_load, pend_save;
    logic [1:0]      take_load, take_save;
    logic [SEC_AW:0] nsec [2];

    bk_state_t         state, state_nx;
    bk_op_t            op, op_nx;
    logic              dev, dev_nx;
    logic [SEC_AW-1:0] sec, sec_nx;
    logic [SEC_AW:0]   cur_nsec, cur_nsec_nx;
    logic [SEC_AW:0]   sec_inc;
    logic              abort, abort_nx;
    logic              busy, ack;
    logic [1:0]        req_vec;

    assign load_edge = bk_load & ~load_q;
    assign save_edge = bk_save & ~save_q & ~load_edge;

    bk_vd_state #(.MAX_SEC(INT_SECTORS), .SEC_AW(SEC_AW)) u_vd0 (
        .clk          (clk_sys),
        .rst_n        (reset_n),
        .mount        (img_mounted[0]),
        .img_readonly (img_readonly),
        .img_size     (img_size),
        .load_req     (load_edge),
        .save_req     (save_edge),
        .take_load    (take_load[0]),
        .take_save    (take_save[0]),
        .mounted      (mounted[0]),
        .nsec         (nsec[0]),
        .pend_load    (pend_load[0]),
        .pend_save    (pend_save[0])
    );

    bk_vd_state #(.MAX_SEC(BMP_SECTORS), .SEC_AW(SEC_AW)) u_vd1 (
        .clk          (clk_sys),
        .rst_n        (reset_n),
        .mount        (img_mounted[1]),
        .img_readonly (img_readonly),
        .img_size     (img_size),
        .load_req     (load_edge),
        .save_req     (save_edge),
        .take_load    (take_load[1]),
        .take_save    (take_save[1]),
        .mounted      (mounted[1]),
        .nsec         (nsec[1]),
        .pend_load    (pend_load[1]),
        .pend_save    (pend_save[1])
    );

    assign ack     = sd_ack[dev];
    assign busy    = (state == REQ) || (state == XFER) || (state == NEXT);
    assign sec_inc = {1'b0, sec} + (SEC_AW+1)'(1);

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state    <= ACKLOW;
            op       <= NONE;
            dev      <= 1'b0;
            sec      <= '0;
            cur_nsec <= '0;
            abort    <= 1'b0;
            load_q   <= 1'b0;
            save_q   <= 1'b0;
        end else begin
            state    <= state_nx;
            op       <= op_nx;
            dev      <= dev_nx;
            sec      <= sec_nx;
            cur_nsec <= cur_nsec_nx;
            abort    <= abort_nx;
            load_q   <= bk_load;
            save_q   <= bk_save;
        end
    end

    always_comb begin
        state_nx    = state;
        op_nx       = op;
        dev_nx      = dev;
        sec_nx      = sec;
        cur_nsec_nx = cur_nsec;
        abort_nx    = abort | (busy & img_mounted[dev]);
        take_load   = '0;
        take_save   = '0;
        unique case (state)
            ACKLOW: begin
                if (sd_ack == '0) state_nx = IDLE;
            end
            IDLE: begin
                abort_nx = 1'b0;
                if ((pend_load | pend_save) != '0) begin
                    dev_nx = ~(pend_load[0] | pend_save[0]);
                    if (pend_load[dev_nx]) begin
                        op_nx = LOAD;
                        take_load[dev_nx] = 1'b1;
                    end else begin
                        op_nx = SAVE;
                        take_save[dev_nx] = 1'b1;
                    end
                    sec_nx      = '0;
                    cur_nsec_nx = nsec[dev_nx];
                    state_nx    = REQ;
                end
            end
            REQ: begin
                if (ack) state_nx = XFER;
            end
            XFER: begin
                if (!ack) state_nx = NEXT;
            end
            NEXT: begin
                sec_nx = sec_inc[SEC_AW-1:0];
                if (sec_inc == cur_nsec || abort_nx) state_nx = IDLE;
                else state_nx = REQ;
            end
            default: state_nx = ACKLOW;
        endcase
    end

    assign req_vec = 2'b01 << dev;
    assign sd_rd   = (state == REQ && op == LOAD) ? req_vec : 2'b00;
    assign sd_wr   = (state == REQ && op == SAVE) ? req_vec : 2'b00;
    assign sd_lba  = 32'(sec);

    assign mem_sel   = dev;
    assign mem_addr  = 16'({sec, sd_buff_addr});
    assign mem_wdata = sd_buff_dout;
    assign mem_we    = sd_buff_wr & ack & (op == LOAD);

    // RAM read data already lags the buffer address by one cycle.
    assign sd_buff_din = (busy && op == SAVE) ? mem_rdata : '0;

    assign bk_busy = busy;
    assign bk_ena  = |mounted;

endmodule

// File: tb/tb_bkram_sd_ctrl.sv
// Scoreboard bench for bkram_sd_ctrl with an HPS sector-transfer model.
// A queue-based reference predicts every sector request and RAM access.
module tb_bkram_sd_ctrl;

    localparam int INT_SEC = 64;
    localparam int BMP_SEC = 256;
    localparam int IDLE_BOUND = 40000;

    logic        clk_sys = 1'b0;
    logic        reset_n = 1'b0;
    logic [1:0]  img_mounted = '0;
    logic        img_readonly = 1'b0;
    logic [63:0] img_size = '0;
    logic        bk_load = 1'b0;
    logic        bk_save = 1'b0;
    logic        bk_ena, bk_busy;
    logic [31:0] sd_lba;
    logic [1:0]  sd_rd, sd_wr;
    logic [1:0]  sd_ack;
    logic [7:0]  sd_buff_addr;
    logic [15:0] sd_buff_dout;
    logic [15:0] sd_buff_din;
    logic        sd_buff_wr;
    logic        mem_sel;
    logic [15:0] mem_addr, mem_wdata;
    logic        mem_we;
    logic [15:0] mem_rdata = '0;

    bkram_sd_ctrl dut (
        .clk_sys      (clk_sys),
        .reset_n      (reset_n),
        .img_mounted  (img_mounted),
        .img_readonly (img_readonly),
        .img_size     (img_size),
        .bk_load      (bk_load),
        .bk_save      (bk_save),
        .bk_ena       (bk_ena),
        .bk_busy      (bk_busy),
        .sd_lba       (sd_lba),
        .sd_rd        (sd_rd),
        .sd_wr        (sd_wr),
        .sd_ack       (sd_ack),
        .sd_buff_addr (sd_buff_addr),
        .sd_buff_dout (sd_buff_dout),
        .sd_buff_din  (sd_buff_din),
        .sd_buff_wr   (sd_buff_wr),
        .mem_sel      (mem_sel),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_we       (mem_we),
        .mem_rdata    (mem_rdata)
    );

    always #5 clk_sys = ~clk_sys;

    typedef struct {
        int vd;
        bit save;
        int lba;
    } req_t;

    req_t        exp_req[$];
    logic [32:0] exp_wr[$];
    logic [15:0] exp_din[$];

    int checks = 0;
    int errors = 0;
    int wr_count = 0;
    int wr1_cycles = 0;

    bit   ack_release = 1'b0;
    bit   hps_busy = 1'b0;
    bit   hps_rd_phase = 1'b0;
    logic hps_vd = 1'b0;
    int   hps_lba = 0;
    int   hps_word = 0;

    int m_mounted[2], m_ro[2], m_nsec[2], m_pl[2], m_ps[2];

    function automatic logic [15:0] mem_f(input logic sel, input logic [15:0] a);
        return (a * 16'd3) ^ (sel ? 16'hA5A5 : 16'h1234);
    endfunction

    always @(posedge clk_sys) mem_rdata <= mem_f(mem_sel, mem_addr);

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic void model_mount(input int vd, input longint unsigned size,
                                        input bit rdo);
        longint unsigned n, cap;
        cap = (vd == 0) ? INT_SEC : BMP_SEC;
        n = (size >> 9) & 64'hFFFF_FFFF;
        if (n > cap) n = cap;
        m_nsec[vd]    = int'(n);
        m_mounted[vd] = (n != 0);
        m_ro[vd]      = rdo;
        m_pl[vd]      = m_mounted[vd];
        m_ps[vd]      = 0;
    endfunction

    function automatic void model_load();
        for (int v = 0; v < 2; v++)
            if (m_mounted[v] != 0) begin
                m_pl[v] = 1;
                m_ps[v] = 0;
            end
    endfunction

    function automatic void model_save();
        for (int v = 0; v < 2; v++)
            if (m_mounted[v] != 0 && m_ro[v] == 0) m_ps[v] = 1;
    endfunction

    // Drain pending work in service order: VD0 first, load before save.
    function automatic void model_run();
        for (int v = 0; v < 2; v++) begin
            if (m_pl[v] != 0) begin
                for (int s = 0; s < m_nsec[v]; s++)
                    exp_req.push_back('{vd: v, save: 1'b0, lba: s});
                m_pl[v] = 0;
            end
            if (m_ps[v] != 0) begin
                for (int s = 0; s < m_nsec[v]; s++)
                    exp_req.push_back('{vd: v, save: 1'b1, lba: s});
                m_ps[v] = 0;
            end
        end
    endfunction

    task automatic do_mount(input int vd, input longint unsigned size,
                            input bit rdo, input bit run);
        @(posedge clk_sys); #1;
        img_mounted  = 2'b01 << vd;
        img_size     = size;
        img_readonly = rdo;
        model_mount(vd, size, rdo);
        if (run) model_run();
        @(posedge clk_sys); #1;
        img_mounted  = '0;
        img_size     = {$urandom, $urandom};
        img_readonly = 1'($urandom);
    endtask

    task automatic osd(input bit ld, input bit sv, input bit run);
        @(posedge clk_sys); #1;
        bk_load = ld;
        bk_save = sv;
        if (ld) model_load();
        else if (sv) model_save();
        if (run) model_run();
        repeat (3) @(posedge clk_sys);
        #1;
        bk_load = 1'b0;
        bk_save = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (!(exp_req.size() == 0 && !bk_busy && !hps_busy) && n < IDLE_BOUND) begin
            @(negedge clk_sys);
            n++;
        end
        repeat (8) @(negedge clk_sys);
        check({name, "_timeout"}, 64'(n >= IDLE_BOUND), 0);
        check({name, "_req_left"}, 64'(exp_req.size()), 0);
        check({name, "_wr_left"}, 64'(exp_wr.size()), 0);
        check({name, "_din_left"}, 64'(exp_din.size()), 0);
        check({name, "_busy"}, 64'(bk_busy), 0);
        check({name, "_din_idle"}, 64'(sd_buff_din), 0);
    endtask

    task automatic wait_hps(input int vd, input int lba, input int word);
        int n;
        n = 0;
        while (!(hps_busy && int'(hps_vd) == vd && hps_lba == lba && hps_word >= word)
               && n < IDLE_BOUND) begin
            @(negedge clk_sys);
            n++;
        end
        check("wait_hps_timeout", 64'(n >= IDLE_BOUND), 0);
    endtask

    // HPS side: acknowledge each request and stream one 256-word sector.
    initial begin : hps
        logic        hsave;
        logic [7:0]  hlba;
        logic [7:0]  wb;
        logic [15:0] d;
        int          dly;
        sd_ack       = 2'b01;
        sd_buff_addr = '0;
        sd_buff_dout = '0;
        sd_buff_wr   = 1'b0;
        wait (ack_release);
        @(posedge clk_sys); #1;
        sd_ack = '0;
        forever begin
            @(posedge clk_sys); #1;
            if ((sd_rd | sd_wr) != '0) begin
                hps_vd   = sd_rd[1] | sd_wr[1];
                hsave    = |sd_wr;
                hlba     = sd_lba[7:0];
                hps_lba  = int'(hlba);
                hps_word = 0;
                hps_busy = 1'b1;
                dly = $urandom_range(0, 2);
                for (int k = 0; k < dly; k++) begin
                    @(posedge clk_sys); #1;
                end
                sd_ack[hps_vd] = 1'b1;
                for (int w = 0; w < 256; w++) begin
                    wb = 8'(w);
                    if (!hsave && $urandom_range(0, 7) == 0) begin
                        sd_buff_wr = 1'b0;
                        @(posedge clk_sys); #1;
                    end
                    sd_buff_addr = wb;
                    hps_word = w;
                    if (!hsave) begin
                        d = 16'($urandom);
                        sd_buff_dout = d;
                        sd_buff_wr = 1'b1;
                        exp_wr.push_back({hps_vd, hlba, wb, d});
                    end else begin
                        hps_rd_phase = 1'b1;
                        exp_din.push_back(mem_f(hps_vd, {hlba, wb}));
                    end
                    @(posedge clk_sys); #1;
                end
                sd_buff_wr   = 1'b0;
                hps_rd_phase = 1'b0;
                sd_ack       = '0;
                hps_busy     = 1'b0;
            end
        end
    end

    // Monitor: requests, RAM writes and save read-back data.
    initial begin : monitor
        req_t        r;
        logic [1:0]  cur;
        logic [1:0]  prev;
        logic [32:0] ew;
        logic [15:0] ed;
        bit          chk;
        prev = '0;
        chk  = 1'b0;
        forever begin
            @(negedge clk_sys);
            if (reset_n) begin
                cur = sd_rd | sd_wr;
                if (sd_wr[1]) wr1_cycles++;
                if (cur != '0 && prev == '0) begin
                    if (exp_req.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_req: rd=%b wr=%b lba=%0d, none expected",
                                 sd_rd, sd_wr, sd_lba);
                    end else begin
                        r = exp_req.pop_front();
                        check("req_rd", 64'(sd_rd), r.save ? 64'd0 : 64'(2'b01 << r.vd));
                        check("req_wr", 64'(sd_wr), r.save ? 64'(2'b01 << r.vd) : 64'd0);
                        check("req_lba", 64'(sd_lba), 64'(r.lba));
                    end
                end
                prev = cur;
                if (mem_we) begin
                    wr_count++;
                    if (exp_wr.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_we: sel=%0d addr=%0h, none expected",
                                 mem_sel, mem_addr);
                    end else begin
                        ew = exp_wr.pop_front();
                        check("mem_write", 64'({mem_sel, mem_addr, mem_wdata}), 64'(ew));
                    end
                end
                if (chk) begin
                    if (exp_din.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL din_underflow: got %0h, nothing expected", sd_buff_din);
                    end else begin
                        ed = exp_din.pop_front();
                        check("save_din", 64'(sd_buff_din), 64'(ed));
                    end
                end
                chk = hps_rd_phase;
            end
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin : main
        for (int v = 0; v < 2; v++) begin
            m_mounted[v] = 0; m_ro[v] = 0; m_nsec[v] = 0; m_pl[v] = 0; m_ps[v] = 0;
        end
        repeat (3) @(posedge clk_sys);
        #1;
        check("rst_busy", 64'(bk_busy), 0);
        check("rst_ena", 64'(bk_ena), 0);
        check("rst_rd", 64'(sd_rd), 0);
        check("rst_wr", 64'(sd_wr), 0);
        check("rst_lba", 64'(sd_lba), 0);
        check("rst_din", 64'(sd_buff_din), 0);
        check("rst_we", 64'(mem_we), 0);
        reset_n = 1'b1;

        // Reset released while HPS still acks: mount must wait for ack low.
        do_mount(0, 64'd4096, 1'b0, 1'b1);
        repeat (6) @(posedge clk_sys);
        #1;
        check("acklow_rd", 64'(sd_rd), 0);
        check("acklow_busy", 64'(bk_busy), 0);
        check("acklow_ena", 64'(bk_ena), 1);
        ack_release = 1'b1;
        wait_idle("acklow");

        wr_count = 0;
        do_mount(0, 64'd32768, 1'b0, 1'b1);
        wait_idle("vd0_full");
        check("vd0_we_count", 64'(wr_count), 64'(64 * 256));

        do_mount(1, 64'd4096, 1'b0, 1'b1);
        wait_idle("vd1_load");
        check("vd1_ena", 64'(bk_ena), 1);

        do_mount(0, 64'd3000, 1'b0, 1'b1);
        wait_idle("vd0_trunc");
        osd(1'b0, 1'b1, 1'b1);
        wait_idle("save_both");

        do_mount(1, 64'd1536, 1'b1, 1'b1);
        wait_idle("vd1_ro_load");
        wr1_cycles = 0;
        osd(1'b0, 1'b1, 1'b1);
        wait_idle("save_ro");
        check("ro_no_wr1", 64'(wr1_cycles), 0);

        osd(1'b1, 1'b1, 1'b1);
        wait_idle("load_wins");

        do_mount(0, (64'd1 << 41) | 64'd1024, 1'b0, 1'b1);
        wait_idle("size_bits");
        do_mount(1, 64'd511, 1'b0, 1'b1);
        check("sub_sector_ena", 64'(bk_ena), 1);
        do_mount(0, 64'd0, 1'b0, 1'b1);
        check("unmounted_ena", 64'(bk_ena), 0);
        osd(1'b1, 1'b0, 1'b1);
        wait_idle("no_media");

        // Abort: re-mount VD0 mid-sector 10 with a smaller image.
        do_mount(0, 64'd16 * 512, 1'b0, 1'b1);
        wait_hps(0, 3, 20);
        osd(1'b0, 1'b1, 1'b0);
        wait_hps(0, 5, 50);
        do_mount(1, 64'd2 * 512, 1'b1, 1'b0);
        wait_hps(0, 10, 100);
        do_mount(0, 64'd12 * 512, 1'b0, 1'b0);
        exp_req.delete();
        model_run();
        wait_idle("abort");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
